// File: rtl/mem_fill_ctrl.sv
// Cache-miss fill controller: streams one aligned block from memory into the cache
// data array and slots single-word write-through stores in between fills.
module mem_fill_ctrl #(
    parameter int  ADDR_WIDTH  = 16,
    parameter int  BLOCK_WORDS = 8,
    localparam int IDX_BITS    = $clog2(BLOCK_WORDS),
    localparam int OFS_BITS    = IDX_BITS + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_req,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic                  wt_req,
    input  logic [ADDR_WIDTH-1:0] wt_addr,
    input  logic [15:0]           wt_data,
    input  logic [15:0]           mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic                  fill_valid,
    output logic [IDX_BITS-1:0]   fill_idx,
    output logic [15:0]           fill_data,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic                  wt_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [IDX_BITS-1:0]   cnt;
    logic [ADDR_WIDTH-1:0] base;
    logic                  accept_miss;
    logic                  last_word;
    logic                  unused_bits;

    // A pending store always wins the IDLE cycle; the miss is taken on the next one.
    assign accept_miss = (state == IDLE) && !wt_req && miss_req;
    assign last_word   = (cnt == IDX_BITS'(BLOCK_WORDS - 1));
    assign unused_bits = ^{miss_addr[OFS_BITS-1:0], wt_addr[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            base  <= '0;
        end else begin
            state <= next_state;
            if (accept_miss) begin
                base <= {miss_addr[ADDR_WIDTH-1:OFS_BITS], {OFS_BITS{1'b0}}};
                cnt  <= '0;
            end else if (state == FILL) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Outputs are held at zero during reset so the memory image load is undisturbed.
    always_comb begin
        next_state = state;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        fill_valid = 1'b0;
        fill_idx   = '0;
        fill_data  = '0;
        fill_busy  = 1'b0;
        fill_done  = 1'b0;
        wt_ack     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (wt_req) begin
                        mem_enable = 1'b1;
                        mem_wr     = 1'b1;
                        mem_addr   = {wt_addr[ADDR_WIDTH-1:1], 1'b0};
                        mem_wdata  = wt_data;
                        wt_ack     = 1'b1;
                    end else if (miss_req) begin
                        next_state = FILL;
                    end
                end
                FILL: begin
                    mem_enable = 1'b1;
                    mem_addr   = base | {{(ADDR_WIDTH-OFS_BITS){1'b0}}, cnt, 1'b0};
                    fill_valid = 1'b1;
                    fill_idx   = cnt;
                    fill_data  = mem_rdata;
                    fill_busy  = 1'b1;
                    if (last_word) begin
                        next_state = DONE;
                    end
                end
                DONE: begin
                    fill_busy  = 1'b1;
                    fill_done  = 1'b1;
                    next_state = IDLE;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Self-checking bench for mem_fill_ctrl: a 16-bit word memory model plus an
// expected-contents model that predicts every fill word and store access.
module tb_mem_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_req = 1'b0;
    logic [15:0] miss_addr = '0;
    logic        wt_req = 1'b0;
    logic [15:0] wt_addr = '0;
    logic [15:0] wt_data = '0;
    logic [15:0] mem_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_enable;
    logic        mem_wr;
    logic        fill_valid;
    logic [2:0]  fill_idx;
    logic [15:0] fill_data;
    logic        fill_busy;
    logic        fill_done;
    logic        wt_ack;

    int          errors = 0;
    int          checks = 0;
    logic [56:0] obs;
    logic [56:0] exp_v;
    logic [15:0] mem [0:32767];
    logic [15:0] model_wr [int];

    mem_fill_ctrl dut (
        .clk(clk), .rst(rst),
        .miss_req(miss_req), .miss_addr(miss_addr),
        .wt_req(wt_req), .wt_addr(wt_addr), .wt_data(wt_data),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_enable(mem_enable), .mem_wr(mem_wr),
        .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data),
        .fill_busy(fill_busy), .fill_done(fill_done), .wt_ack(wt_ack)
    );

    always #5 clk = ~clk;

    assign obs = {mem_addr, mem_wdata, mem_enable, mem_wr, fill_valid, fill_idx,
                  fill_data, fill_busy, fill_done, wt_ack};

    // Initial memory image; words 0x918..0x91F (bytes 0x1230..0x123E) hold 0xA000+i.
    function automatic logic [15:0] init_word(int wi);
        if (wi >= 'h918 && wi <= 'h91F) return 16'hA000 + 16'(wi - 'h918);
        return 16'(wi * 40503) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] expect_word(logic [15:0] byte_addr);
        int wi;
        wi = int'(byte_addr[15:1]);
        if (model_wr.exists(wi)) return model_wr[wi];
        return init_word(wi);
    endfunction

    // Single-cycle memory: combinational read, write at the clock edge.
    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_enable && mem_wr) mem[mem_addr[15:1]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[15:1]];

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation still running, expected completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wt_req = 1'b1;
        wt_addr = 16'h0100;
        wt_data = 16'h1234;
        for (int c = 0; c < 2; c++) begin
            step();
            #1;
            checks++;
            if (obs !== 57'h0) begin
                errors++;
                $display("[TB] FAIL reset_hold cycle %0d: got %h expected %h", c, obs, 57'h0);
            end
        end
        rst = 1'b0;
        wt_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            #1;
            checks++;
            if (obs !== 57'h0) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d: got %h expected %h", c, obs, 57'h0);
            end
        end
    endtask

    task automatic test_fill(input logic [15:0] addr);
        logic [15:0] base;
        logic [15:0] a;
        base = addr & 16'hFFF0;
        step();
        wt_req = 1'b0;
        miss_req = 1'b1;
        miss_addr = addr;
        #1;
        checks++;
        if (obs !== 57'h0) begin
            errors++;
            $display("[TB] FAIL fill_accept_idle addr %h: got %h expected %h", addr, obs, 57'h0);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            #1;
            a = base + 16'(2 * i);
            exp_v = {a, 16'h0, 1'b1, 1'b0, 1'b1, 3'(i), expect_word(a), 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("[TB] FAIL fill_word addr %h idx %0d: got %h expected %h", addr, i, obs, exp_v);
            end
        end
        step();
        #1;
        exp_v = {16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'b0, 16'h0, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL fill_done addr %h: got %h expected %h", addr, obs, exp_v);
        end
        miss_req = 1'b0;
    endtask

    task automatic test_store(input logic [15:0] addr, input logic [15:0] data);
        step();
        wt_req = 1'b1;
        wt_addr = addr;
        wt_data = data;
        #1;
        exp_v = {addr & 16'hFFFE, data, 1'b1, 1'b1, 1'b0, 3'b0, 16'h0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL store_ack addr %h: got %h expected %h", addr, obs, exp_v);
        end
        model_wr[int'(addr[15:1])] = data;
        step();
        wt_req = 1'b0;
        #1;
        checks++;
        if (obs !== 57'h0) begin
            errors++;
            $display("[TB] FAIL store_release addr %h: got %h expected %h", addr, obs, 57'h0);
        end
    endtask

    task automatic test_store_and_miss();
        step();
        wt_req = 1'b1;
        wt_addr = 16'h2004;
        wt_data = 16'h5555;
        miss_req = 1'b1;
        miss_addr = 16'h2000;
        #1;
        exp_v = {16'h2004, 16'h5555, 1'b1, 1'b1, 1'b0, 3'b0, 16'h0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL store_miss_order: got %h expected %h", obs, exp_v);
        end
        model_wr[int'(16'h1002)] = 16'h5555;
        test_fill(16'h2000);
    endtask

    task automatic test_wt_during_fill();
        logic [15:0] a;
        step();
        miss_req = 1'b1;
        miss_addr = 16'h3456;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 2) begin
                wt_req = 1'b1;
                wt_addr = 16'h345D;
                wt_data = 16'hC0DE;
            end
            #1;
            a = 16'h3450 + 16'(2 * i);
            exp_v = {a, 16'h0, 1'b1, 1'b0, 1'b1, 3'(i), expect_word(a), 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("[TB] FAIL wt_wait_fill idx %0d: got %h expected %h", i, obs, exp_v);
            end
        end
        step();
        #1;
        exp_v = {16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'b0, 16'h0, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL wt_wait_done: got %h expected %h", obs, exp_v);
        end
        miss_req = 1'b0;
        step();
        #1;
        exp_v = {16'h345C, 16'hC0DE, 1'b1, 1'b1, 1'b0, 3'b0, 16'h0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL wt_served_after_done: got %h expected %h", obs, exp_v);
        end
        model_wr[int'(16'h1A2E)] = 16'hC0DE;
        step();
        wt_req = 1'b0;
        test_fill(16'h3450);
    endtask

    task automatic test_reset_mid_fill();
        logic [15:0] a;
        step();
        miss_req = 1'b1;
        miss_addr = 16'h7A3E;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            a = 16'h7A30 + 16'(2 * i);
            exp_v = {a, 16'h0, 1'b1, 1'b0, 1'b1, 3'(i), expect_word(a), 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("[TB] FAIL rst_fill_word idx %0d: got %h expected %h", i, obs, exp_v);
            end
        end
        step();
        rst = 1'b1;
        miss_req = 1'b0;
        #1;
        checks++;
        if (obs !== 57'h0) begin
            errors++;
            $display("[TB] FAIL rst_mid_fill_hold: got %h expected %h", obs, 57'h0);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (obs !== 57'h0) begin
                errors++;
                $display("[TB] FAIL rst_no_done cycle %0d: got %h expected %h", c, obs, 57'h0);
            end
            step();
        end
        test_fill(16'h7A3E);
    endtask

    task automatic test_back_to_back();
        test_fill(16'($urandom));
        test_fill(16'($urandom));
    endtask

    task automatic test_random();
        logic [15:0] sa;
        logic [15:0] fa;
        for (int k = 0; k < 6; k++) begin
            sa = 16'($urandom);
            test_store(sa, 16'($urandom));
            fa = ($urandom_range(0, 1) == 1) ? sa : 16'($urandom);
            test_fill(fa);
        end
    endtask

    initial begin
        test_reset();
        test_fill(16'h123A);
        test_store(16'h0041, 16'hBEEF);
        test_fill(16'h0040);
        test_store_and_miss();
        test_wt_during_fill();
        test_reset_mid_fill();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
